// File: rtl/cc_sar_threshold_search.sv
// Successive-approximation search that recovers an unknown word X by steering the
// trial operand of an external greater-than comparator, MSB first.
module cc_sar_threshold_search #(
    parameter int NUMBER_DATAWIDTH = 8,
    parameter int COMPARE_LATENCY  = 1
) (
    input  logic                        CC_SAR_CLOCK_50,
    input  logic                        CC_SAR_RESET_InHigh,
    input  logic                        CC_SAR_start_In,
    input  logic                        CC_SAR_greaterthan_In,
    output logic [NUMBER_DATAWIDTH-1:0] CC_SAR_trial_OutBUS,
    output logic                        CC_SAR_busy_Out,
    output logic                        CC_SAR_done_Out,
    output logic [NUMBER_DATAWIDTH-1:0] CC_SAR_result_OutBUS
);

    typedef enum logic [1:0] {
        IDLE,
        TEST,
        DONE
    } sarState_e;

    localparam logic [NUMBER_DATAWIDTH-1:0] MSB_ONE = {1'b1, {(NUMBER_DATAWIDTH-1){1'b0}}};
    // The bit index and the wait counter are kept one-hot so stepping them is a
    // plain shift; waitOneHot[0] set means the counter has reached zero.
    localparam logic [14:0] WAIT_RELOAD = 15'b1 << (COMPARE_LATENCY - 1);

    sarState_e                   state, stateNext;
    logic [NUMBER_DATAWIDTH-1:0] trial, trialNext;
    logic [NUMBER_DATAWIDTH-1:0] bitMask, bitMaskNext;
    logic [NUMBER_DATAWIDTH-1:0] result, resultNext;
    logic [NUMBER_DATAWIDTH-1:0] decided;
    logic [14:0]                 waitOneHot, waitOneHotNext;

    always_ff @(posedge CC_SAR_CLOCK_50) begin
        if (CC_SAR_RESET_InHigh) begin
            state      <= IDLE;
            trial      <= '0;
            bitMask    <= MSB_ONE;
            waitOneHot <= 15'b1;
            result     <= '0;
        end else begin
            state      <= stateNext;
            trial      <= trialNext;
            bitMask    <= bitMaskNext;
            waitOneHot <= waitOneHotNext;
            result     <= resultNext;
        end
    end

    // A greater-than answer means the trial overshot X, so the bit under test is dropped.
    assign decided = CC_SAR_greaterthan_In ? (trial & ~bitMask) : trial;

    always_comb begin
        stateNext      = state;
        trialNext      = trial;
        bitMaskNext    = bitMask;
        waitOneHotNext = waitOneHot;
        resultNext     = result;
        case (state)
            IDLE: begin
                if (CC_SAR_start_In) begin
                    stateNext      = TEST;
                    trialNext      = MSB_ONE;
                    bitMaskNext    = MSB_ONE;
                    waitOneHotNext = WAIT_RELOAD;
                end
            end
            TEST: begin
                if (!waitOneHot[0]) begin
                    waitOneHotNext = waitOneHot >> 1;
                end else if (!bitMask[0]) begin
                    trialNext      = decided | (bitMask >> 1);
                    bitMaskNext    = bitMask >> 1;
                    waitOneHotNext = WAIT_RELOAD;
                end else begin
                    trialNext  = decided;
                    resultNext = decided;
                    stateNext  = DONE;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign CC_SAR_trial_OutBUS  = trial;
    assign CC_SAR_result_OutBUS = result;
    assign CC_SAR_busy_Out      = (state == TEST);
    assign CC_SAR_done_Out      = (state == DONE);

endmodule

// File: tb/tb_cc_sar_threshold_search.sv
// Bench for cc_sar_threshold_search: four instances with comparator latencies 1..4,
// each answered by a behavioural greater-than comparator with matching pipeline depth.
module tb_cc_sar_threshold_search;

    localparam int N     = 8;
    localparam int LANES = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         startArr  [LANES];
    logic         gtArr     [LANES];
    logic [N-1:0] xVal      [LANES];
    logic [N-1:0] trialArr  [LANES];
    logic [N-1:0] resultArr [LANES];
    logic         busyArr   [LANES];
    logic         doneArr   [LANES];

    int checks = 0;
    int errors = 0;
    logic [N-1:0] trialLog[$];

    always #10 clk = ~clk;

    // Lane g uses COMPARE_LATENCY g+1; the comparator result passes through g register stages.
    generate
        for (genvar g = 0; g < LANES; g++) begin : laneGen
            cc_sar_threshold_search #(
                .NUMBER_DATAWIDTH(N),
                .COMPARE_LATENCY (g + 1)
            ) dut (
                .CC_SAR_CLOCK_50      (clk),
                .CC_SAR_RESET_InHigh  (reset),
                .CC_SAR_start_In      (startArr[g]),
                .CC_SAR_greaterthan_In(gtArr[g]),
                .CC_SAR_trial_OutBUS  (trialArr[g]),
                .CC_SAR_busy_Out      (busyArr[g]),
                .CC_SAR_done_Out      (doneArr[g]),
                .CC_SAR_result_OutBUS (resultArr[g])
            );
            if (g == 0) begin : cmpComb
                assign gtArr[g] = (trialArr[g] > xVal[g]);
            end else begin : cmpPipe
                logic [g-1:0] pipe;
                always @(posedge clk) begin
                    pipe[0] <= (trialArr[g] > xVal[g]);
                    for (int i = 1; i < g; i++) pipe[i] <= pipe[i-1];
                end
                assign gtArr[g] = pipe[g-1];
            end
        end
    endgenerate

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Starts one conversion on a lane, logs the trial word every cycle and checks timing and result.
    task automatic applyStimulus(input int lane, input logic [N-1:0] x, input string tag);
        int lat;
        int busyCycles;
        int expLat;
        logic [N-1:0] seenResult;
        expLat     = N * (lane + 1);
        lat        = -1;
        busyCycles = 0;
        seenResult = '0;
        trialLog.delete();
        xVal[lane]     = x;
        startArr[lane] = 1'b1;
        @(negedge clk);
        startArr[lane] = 1'b0;
        for (int c = 0; c < 200 && lat < 0; c++) begin
            trialLog.push_back(trialArr[lane]);
            if (busyArr[lane]) busyCycles++;
            if (doneArr[lane]) begin
                lat        = c;
                seenResult = resultArr[lane];
            end else begin
                @(negedge clk);
            end
        end
        if (lat < 0) begin
            checkOutput({tag, " timeout"}, 32'd0, 32'd1);
        end else begin
            checkOutput({tag, " latency"}, lat, expLat);
            checkOutput({tag, " result"}, seenResult, x);
            checkOutput({tag, " busyCycles"}, busyCycles, expLat);
            @(negedge clk);
            checkOutput({tag, " doneLow"}, doneArr[lane], 1'b0);
            checkOutput({tag, " busyLow"}, busyArr[lane], 1'b0);
        end
    endtask

    logic [N-1:0] seqA5 [8];
    logic         sawDone;

    initial begin
        seqA5 = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
        for (int l = 0; l < LANES; l++) begin
            startArr[l] = 1'b0;
            xVal[l]     = '0;
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        for (int l = 0; l < LANES; l += 3) begin
            checkOutput($sformatf("reset busy lane%0d", l), busyArr[l], 1'b0);
            checkOutput($sformatf("reset done lane%0d", l), doneArr[l], 1'b0);
            checkOutput($sformatf("reset trial lane%0d", l), trialArr[l], 8'h00);
            checkOutput($sformatf("reset result lane%0d", l), resultArr[l], 8'h00);
        end

        applyStimulus(0, 8'hA5, "xA5");
        for (int k = 0; k < 8; k++)
            checkOutput($sformatf("xA5 trial%0d", k), trialLog[k], seqA5[k]);

        applyStimulus(0, 8'h00, "x00");
        checkOutput("x00 finalTrial", trialLog[8], 8'h00);
        applyStimulus(0, 8'hFF, "xFF");
        checkOutput("xFF finalTrial", trialLog[8], 8'hFF);
        checkOutput("xFF trial3", trialLog[3], 8'hF0);

        applyStimulus(2, 8'h3C, "L3 x3C");
        checkOutput("L3 trial0", trialLog[0], 8'h80);
        checkOutput("L3 trial2", trialLog[2], 8'h80);
        checkOutput("L3 trial3", trialLog[3], 8'h40);
        checkOutput("L3 trial23", trialLog[23], 8'h3D);
        checkOutput("L3 trial24", trialLog[24], 8'h3C);

        // Held start: 8 busy cycles, one done cycle, one idle cycle, then the next accept.
        xVal[0]     = 8'h5A;
        startArr[0] = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            checkOutput($sformatf("b2b busy c%0d", c), busyArr[0], ((c % 10) < 8));
            checkOutput($sformatf("b2b done c%0d", c), doneArr[0], ((c % 10) == 8));
            if ((c % 10) == 8) checkOutput($sformatf("b2b result c%0d", c), resultArr[0], 8'h5A);
        end
        startArr[0] = 1'b0;
        @(negedge clk);
        checkOutput("b2b stopped", busyArr[0], 1'b0);

        xVal[0]     = 8'h77;
        startArr[0] = 1'b1;
        @(negedge clk);
        startArr[0] = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort busy", busyArr[0], 1'b0);
        checkOutput("abort done", doneArr[0], 1'b0);
        checkOutput("abort trial", trialArr[0], 8'h00);
        checkOutput("abort result", resultArr[0], 8'h00);
        sawDone = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (doneArr[0] || busyArr[0]) sawDone = 1'b1;
        end
        checkOutput("abort quiet", sawDone, 1'b0);
        applyStimulus(0, 8'h77, "x77 after abort");

        for (int i = 0; i < 500; i++) begin
            int lane;
            int gap;
            logic [N-1:0] x;
            lane = $urandom_range(0, LANES - 1);
            x    = N'($urandom_range(0, 255));
            gap  = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
            applyStimulus(lane, x, $sformatf("sweep%0d lane%0d", i, lane));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
